// File: rtl/req_fifo_reader_if.sv
// req_fifo_reader_if: FIFO-pop and request handshake bundle between the FIFO, reader and cache controller.
// Ports: fifo_buf_out, fifo_buf_empty (FIFO to reader), fifo_rd_en (reader to FIFO),
//        req_valid, req_op, req_idx (reader to controller), req_ready (controller to reader).
interface req_fifo_reader_if #(parameter int DATA_W = 4);
  logic [DATA_W-1:0] fifo_buf_out;
  logic fifo_buf_empty;
  logic fifo_rd_en;
  logic req_valid;
  logic req_op;
  logic [DATA_W-2:0] req_idx;
  logic req_ready;
  modport master(
    input fifo_buf_out, fifo_buf_empty, req_ready,
    output fifo_rd_en, req_valid, req_op, req_idx
  );
  modport slave(
    output fifo_buf_out, fifo_buf_empty, req_ready,
    input fifo_rd_en, req_valid, req_op, req_idx
  );
endinterface

// File: rtl/req_fifo_reader.sv
// req_fifo_reader: pops request FIFO entries, decodes them into op/index and issues them over valid/ready.
// Ports: clk, rst (async, active-high); en (allow new pops), flush (pop and drop entries);
//        bus (req_fifo_reader_if.master: FIFO read side and request handshake);
//        busy (state != IDLE), issued_cnt (accepted requests), err_timeout (sticky handshake timeout).
module req_fifo_reader #(
  parameter int DATA_W = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic flush,
  req_fifo_reader_if.master bus,
  output logic busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic err_timeout
);
  localparam int WAIT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, POP, LATCH, ISSUE} state_t;
  state_t state, state_n;
  logic rd_en, rd_en_n;
  logic valid, valid_n;
  logic op, op_n;
  logic [DATA_W-2:0] idx, idx_n;
  logic [CNT_W-1:0] cnt_n;
  logic err_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  always_comb begin
    state_n = state;
    rd_en_n = 1'b0;
    valid_n = valid;
    op_n = op;
    idx_n = idx;
    cnt_n = issued_cnt;
    err_n = err_timeout;
    wait_n = wait_cnt;
    case (state)
      IDLE: if (!bus.fifo_buf_empty && (en || flush)) begin
        state_n = POP;
        rd_en_n = 1'b1;
      end
      POP: state_n = LATCH;
      LATCH: if (flush) state_n = IDLE;
      else begin
        state_n = ISSUE;
        op_n = bus.fifo_buf_out[DATA_W-1];
        idx_n = bus.fifo_buf_out[DATA_W-2:0];
        valid_n = 1'b1;
        wait_n = '0;
      end
      ISSUE: if (bus.req_ready) begin
        state_n = IDLE;
        valid_n = 1'b0;
        cnt_n = issued_cnt + 1'b1;
      end else if (flush) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end else if (TIMEOUT != 0 && wait_cnt != WAIT_MAX) begin
        // the counter parks at TIMEOUT; err sets on the stall that reaches it
        wait_n = wait_cnt + 1'b1;
        err_n = err_timeout | (wait_n == WAIT_MAX);
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_en <= 1'b0;
      valid <= 1'b0;
      op <= 1'b0;
      idx <= '0;
      busy <= 1'b0;
      issued_cnt <= '0;
      err_timeout <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      rd_en <= rd_en_n;
      valid <= valid_n;
      op <= op_n;
      idx <= idx_n;
      busy <= state_n != IDLE;
      issued_cnt <= cnt_n;
      err_timeout <= err_n;
      wait_cnt <= wait_n;
    end
  end
  assign bus.fifo_rd_en = rd_en;
  assign bus.req_valid = valid;
  assign bus.req_op = op;
  assign bus.req_idx = idx;
endmodule

// File: tb/tb_req_fifo_reader.sv
// tb_req_fifo_reader: directed stimulus with a scoreboard of expected requests checked by a monitor.
module tb_req_fifo_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic flush = 1'b0;
  logic busy, err_timeout;
  logic [15:0] issued_cnt;
  req_fifo_reader_if #(.DATA_W(4)) bus ();
  req_fifo_reader #(.DATA_W(4), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus.master),
    .busy(busy), .issued_cnt(issued_cnt), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  logic [3:0] fifo_q[$];
  logic [3:0] exp_q[$];
  int underflow = 0;
  int pulses = 0;
  int vflush = 0;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (fifo_q.size() == 0) underflow <= underflow + 1;
      else bus.fifo_buf_out <= fifo_q.pop_front();
    end
  end
  always @(negedge clk) bus.fifo_buf_empty <= fifo_q.size() == 0;
  bit seen = 0;
  bit prev_held = 0;
  int low_run = 0;
  logic [3:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_held = 0;
      seen = 0;
      low_run = 0;
    end else begin
      if (bus.fifo_rd_en) begin
        pulses++;
        if (seen) check("rd_en_gap", int'(low_run >= (flush ? 2 : 3)), 1);
        seen = 1;
        low_run = 0;
      end else low_run++;
      if (flush && bus.req_valid) vflush++;
      if (prev_held) begin
        check("hold_valid", int'(bus.req_valid), 1);
        check("hold_data", int'({bus.req_op, bus.req_idx}), int'(held));
      end
      if (bus.req_valid && bus.req_ready) begin
        check("sb_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sb_req", int'({bus.req_op, bus.req_idx}), int'(exp_q.pop_front()));
      end
      prev_held = bus.req_valid && !bus.req_ready && !flush;
      held = {bus.req_op, bus.req_idx};
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] entry, input bit expect_it, input logic op, input logic [2:0] idx);
    fifo_q.push_back(entry);
    if (expect_it) exp_q.push_back({op, idx});
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.req_valid && n < 12) begin
      tick();
      n++;
    end
    check("valid_arrives", int'(bus.req_valid), 1);
  endtask
  int n, p0;
  initial begin
    bus.req_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", int'(bus.req_valid), 0);
    check("rst_rd_en", int'(bus.fifo_rd_en), 0);
    check("rst_op_idx", int'({bus.req_op, bus.req_idx}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(issued_cnt), 0);
    check("rst_err", int'(err_timeout), 0);
    en = 1'b1;
    repeat (20) tick();
    check("idle_no_pulse", pulses, 0);
    // single request: rd_en next edge, valid two edges later
    push(4'b0101, 1, 1'b0, 3'd5);
    bus.req_ready = 1'b1;
    tick();
    check("t2_rd_en_hi", int'(bus.fifo_rd_en), 1);
    check("t2_busy", int'(busy), 1);
    tick();
    check("t2_rd_en_lo", int'(bus.fifo_rd_en), 0);
    check("t2_valid_lo", int'(bus.req_valid), 0);
    tick();
    check("t2_valid_hi", int'(bus.req_valid), 1);
    check("t2_op", int'(bus.req_op), 0);
    check("t2_idx", int'(bus.req_idx), 5);
    tick();
    check("t2_valid_drop", int'(bus.req_valid), 0);
    check("t2_cnt", int'(issued_cnt), 1);
    check("t2_idle", int'(busy), 0);
    // back-to-back with a 5-cycle stall on the first
    bus.req_ready = 1'b0;
    push(4'b1010, 1, 1'b1, 3'd2);
    push(4'b0011, 1, 1'b0, 3'd3);
    wait_valid(n);
    check("t3_latency", n, 3);
    check("t3_op", int'(bus.req_op), 1);
    check("t3_idx", int'(bus.req_idx), 2);
    repeat (5) tick();
    bus.req_ready = 1'b1;
    tick();
    check("t3_accept", int'(bus.req_valid), 0);
    wait_valid(n);
    check("t3_next_valid", n, 3);
    check("t3_op2", int'(bus.req_op), 0);
    check("t3_idx2", int'(bus.req_idx), 3);
    tick();
    check("t3_cnt", int'(issued_cnt), 3);
    check("t3_err", int'(err_timeout), 0);
    // flush: three entries popped and dropped
    en = 1'b0;
    flush = 1'b1;
    bus.req_ready = 1'b0;
    p0 = pulses;
    push(4'b1001, 0, 1'b0, 3'd0);
    push(4'b0110, 0, 1'b0, 3'd0);
    push(4'b1111, 0, 1'b0, 3'd0);
    repeat (20) tick();
    check("t4_pulses", pulses - p0, 3);
    check("t4_empty", int'(bus.fifo_buf_empty), 1);
    check("t4_cnt", int'(issued_cnt), 3);
    check("t4_no_valid", vflush, 0);
    flush = 1'b0;
    // timeout after 8 stalled ISSUE cycles
    en = 1'b1;
    push(4'b1110, 1, 1'b1, 3'd6);
    wait_valid(n);
    n = 0;
    while (!err_timeout && n < 20) begin
      tick();
      n++;
    end
    check("t5_err_cycles", n, 8);
    check("t5_held", int'(bus.req_valid), 1);
    bus.req_ready = 1'b1;
    tick();
    check("t5_accept", int'(bus.req_valid), 0);
    check("t5_cnt", int'(issued_cnt), 4);
    repeat (5) tick();
    check("t5_err_sticky", int'(err_timeout), 1);
    // asynchronous reset in ISSUE
    bus.req_ready = 1'b0;
    push(4'b0001, 1, 1'b0, 3'd1);
    wait_valid(n);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", int'(bus.req_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_cnt", int'(issued_cnt), 0);
    check("t6_err", int'(err_timeout), 0);
    check("t6_sb_left", exp_q.size(), 1);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("underflow", underflow, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
